// File: rtl/float_pkg.sv
// Shared types and constants for the sequential single-precision adder.
package float_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 23;
  localparam int unsigned MAX_ALIGN = 25;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam logic [31:0]      INF_PAT = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_e;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits a float into sign/exponent/mantissa (hidden bit prepended) and
// classifies zero/denormal and Inf/NaN encodings.
module fp_unpack #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       man_o,
  output logic                 zero_o,
  output logic                 special_o
);

  // Field split and classification
  always_comb begin
    sign_o    = x_i[EXP_W+MAN_W];
    exp_o     = x_i[EXP_W+MAN_W-1:MAN_W];
    man_o     = {1'b1, x_i[MAN_W-1:0]};
    zero_o    = (exp_o == '0);
    special_o = (exp_o == '1);
  end

endmodule

// File: rtl/float_add_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract. One datapath step per
// clock: unpack, align (1 bit/cycle), add/sub, normalize (1 bit/cycle), pack.
// Truncating arithmetic, denormals flushed to zero, start/done handshake.
module float_add_seq #(
  parameter int unsigned EXP_W     = float_pkg::EXP_W,
  parameter int unsigned MAN_W     = float_pkg::MAN_W,
  parameter int unsigned MAX_ALIGN = float_pkg::MAX_ALIGN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   s,
  output logic                   overflow
);

  import float_pkg::*;

  localparam int unsigned W  = EXP_W + MAN_W + 1;
  localparam int unsigned CW = $clog2(MAX_ALIGN + 1);

  localparam logic [EXP_W-1:0] MAX_ALIGN_E = EXP_W'(MAX_ALIGN);
  localparam logic [CW-1:0]    MAX_ALIGN_C = CW'(MAX_ALIGN);
  localparam logic [EXP_W-1:0] EXP_ONES    = '1;
  localparam logic [W-1:0]     INF_RES     = {1'b0, EXP_ONES, {MAN_W{1'b0}}};

  state_e             state_q, state_d;
  logic [W-1:0]       opa_q, opa_d, opb_q, opb_d;
  logic [MAN_W:0]     mx_q, mx_d, my_q, my_d;
  logic               sx_q, sx_d, sy_q, sy_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [MAN_W+1:0]   sum_q, sum_d;
  logic               sign_q, sign_d;
  logic [W-1:0]       res_q, res_d;
  logic               rovf_q, rovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W-1:0]       s_q, s_d;
  logic               ovf_q, ovf_d;

  logic               ua_sign, ub_sign, ua_zero, ub_zero, ua_spec, ub_spec;
  logic [EXP_W-1:0]   ua_exp, ub_exp;
  logic [MAN_W:0]     ua_man, ub_man;
  logic               a_ge_b;
  logic [EXP_W-1:0]   ediff;
  logic [CW-1:0]      dsh;
  logic [MAN_W+1:0]   norm_sum;
  logic [EXP_W-1:0]   norm_exp;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x_i       (opa_q),
    .sign_o    (ua_sign),
    .exp_o     (ua_exp),
    .man_o     (ua_man),
    .zero_o    (ua_zero),
    .special_o (ua_spec)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x_i       (opb_q),
    .sign_o    (ub_sign),
    .exp_o     (ub_exp),
    .man_o     (ub_man),
    .zero_o    (ub_zero),
    .special_o (ub_spec)
  );

  // Exponent difference, clamped so oversized gaps shift the mantissa to zero
  always_comb begin
    a_ge_b = (ua_exp >= ub_exp);
    ediff  = a_ge_b ? (ua_exp - ub_exp) : (ub_exp - ua_exp);
    dsh    = (ediff > MAX_ALIGN_E) ? MAX_ALIGN_C : ediff[CW-1:0];
  end

  // Single normalization step: right on carry-out, left while hidden bit clear
  always_comb begin
    norm_sum = sum_q;
    norm_exp = exp_q;
    if (sum_q[MAN_W+1]) begin
      norm_sum = sum_q >> 1;
      norm_exp = exp_q + EXP_W'(1);
    end else if (!sum_q[MAN_W]) begin
      norm_sum = sum_q << 1;
      norm_exp = exp_q - EXP_W'(1);
    end
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    mx_d    = mx_q;
    my_d    = my_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sign_d  = sign_q;
    res_d   = res_q;
    rovf_d  = rovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b ^ {op, {(W-1){1'b0}}};
          rovf_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        if (ua_spec || ub_spec) begin
          res_d   = INF_RES;
          rovf_d  = 1'b1;
          state_d = DONE;
        end else if (ua_zero) begin
          res_d   = opb_q;
          state_d = DONE;
        end else if (ub_zero) begin
          res_d   = opa_q;
          state_d = DONE;
        end else begin
          // x holds the larger-exponent operand, y is the one to be shifted
          if (a_ge_b) begin
            mx_d  = ua_man;
            sx_d  = ua_sign;
            my_d  = ub_man;
            sy_d  = ub_sign;
            exp_d = ua_exp;
          end else begin
            mx_d  = ub_man;
            sx_d  = ub_sign;
            my_d  = ua_man;
            sy_d  = ua_sign;
            exp_d = ub_exp;
          end
          cnt_d   = dsh;
          state_d = (dsh == '0) ? ADD : ALIGN;
        end
      end

      ALIGN: begin
        my_d  = my_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ADD;
        end
      end

      ADD: begin
        if (sx_q == sy_q) begin
          sum_d   = {1'b0, mx_q} + {1'b0, my_q};
          sign_d  = sx_q;
          state_d = NORM;
        end else if (mx_q == my_q) begin
          res_d   = '0;
          state_d = DONE;
        end else if (mx_q > my_q) begin
          sum_d   = {1'b0, mx_q} - {1'b0, my_q};
          sign_d  = sx_q;
          state_d = NORM;
        end else begin
          sum_d   = {1'b0, my_q} - {1'b0, mx_q};
          sign_d  = sy_q;
          state_d = NORM;
        end
      end

      NORM: begin
        sum_d = norm_sum;
        exp_d = norm_exp;
        if (norm_exp == EXP_ONES) begin
          res_d   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
          rovf_d  = 1'b1;
          state_d = DONE;
        end else if (norm_exp == '0) begin
          res_d   = {sign_q, {(W-1){1'b0}}};
          state_d = DONE;
        end else if (!norm_sum[MAN_W+1] && norm_sum[MAN_W]) begin
          res_d   = {sign_q, norm_exp, norm_sum[MAN_W-1:0]};
          state_d = DONE;
        end
      end

      DONE: begin
        s_d     = res_q;
        ovf_d   = rovf_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      exp_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      rovf_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      rovf_q  <= rovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign s        = s_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_float_add_seq.sv
// Self-checking bench for float_add_seq: scoreboard of expected results,
// one task per scenario.
module tb_float_add_seq;
  import float_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        overflow;

  float_add_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] s;
    logic        ovf;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Called at #1 after a posedge with the DUT idle; returns #1 after the accept edge.
  task automatic pulse_start(input logic [31:0] ta, input logic [31:0] tb_v, input logic top);
    a     = ta;
    b     = tb_v;
    op    = top;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after accept until done is seen; bounded.
  task automatic wait_done(output int lat, output bit to, output bit busy_ok);
    lat     = 0;
    to      = 1'b1;
    busy_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else passes++;
    checks++; if (s !== 32'h0) $display("FAIL reset_s got=%h want=00000000", s); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b want=0", overflow); else passes++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    vec_t v[12];
    exp_t e;
    int   lat;
    bit   to;
    bit   bok;
    v[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4};
    v[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 3};
    v[2]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 5};
    v[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, INF_PAT,      1'b1, 4};
    v[4]  = '{32'h7FC00000, 32'h12345678, 1'b0, INF_PAT,      1'b1, 2};
    v[5]  = '{32'h3F800000, 32'hFF800000, 1'b0, INF_PAT,      1'b1, 2};
    v[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 28};
    v[7]  = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 1'b0, 2};
    v[8]  = '{32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 1'b0, 2};
    v[9]  = '{32'h3F800000, 32'h30000000, 1'b0, 32'h3F800000, 1'b0, 29};
    v[10] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000, 1'b0, 27};
    v[11] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 4};
    for (int i = 0; i < 12; i++) begin
      sb.push_back('{v[i].s, v[i].ovf, v[i].lat});
      pulse_start(v[i].a, v[i].b, v[i].op);
      wait_done(lat, to, bok);
      e = sb.pop_front();
      checks++;
      if (to) $display("FAIL vec%0d_timeout got=no_done want=done", i);
      else if (lat !== e.lat) $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, e.lat);
      else passes++;
      checks++; if (s !== e.s) $display("FAIL vec%0d_s got=%h want=%h", i, s, e.s); else passes++;
      checks++; if (overflow !== e.ovf) $display("FAIL vec%0d_ovf got=%b want=%b", i, overflow, e.ovf); else passes++;
      checks++; if (bok !== 1'b1) $display("FAIL vec%0d_busy_while_running got=low want=high", i); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL vec%0d_busy_at_done got=%b want=0", i, busy); else passes++;
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) $display("FAIL vec%0d_done_pulse_width got=%b want=0", i, done); else passes++;
    end
  endtask

  task automatic test_ignore_start();
    exp_t        e;
    int          dones = 0;
    int          got_lat = 0;
    logic [31:0] got_s = 'x;
    logic        got_ovf = 1'bx;
    sb.push_back('{32'h40000000, 1'b0, 4});
    pulse_start(32'h3F800000, 32'h3F800000, 1'b0);
    a     = 32'h7FC00000;
    b     = 32'h00000000;
    op    = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      start = (i <= 2);
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          got_s   = s;
          got_ovf = overflow;
          got_lat = i;
        end
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++; if (dones !== 1) $display("FAIL ignore_done_count got=%0d want=1", dones); else passes++;
    checks++; if (got_s !== e.s) $display("FAIL ignore_s got=%h want=%h", got_s, e.s); else passes++;
    checks++; if (got_ovf !== e.ovf) $display("FAIL ignore_ovf got=%b want=%b", got_ovf, e.ovf); else passes++;
    checks++; if (got_lat !== e.lat) $display("FAIL ignore_latency got=%0d want=%0d", got_lat, e.lat); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL ignore_idle_after got=%b want=0", busy); else passes++;
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    bit   to;
    bit   bok;
    int   stray = 0;
    pulse_start(32'h3F800000, 32'h33800000, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL abort_done got=%b want=0", done); else passes++;
    checks++; if (s !== 32'h0) $display("FAIL abort_s got=%h want=00000000", s); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL abort_ovf got=%b want=0", overflow); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) stray++;
    end
    checks++; if (stray !== 0) $display("FAIL abort_stray_done got=%0d want=0", stray); else passes++;
    sb.push_back('{32'h40000000, 1'b0, 5});
    pulse_start(32'h40400000, 32'h3F800000, 1'b1);
    wait_done(lat, to, bok);
    e = sb.pop_front();
    checks++;
    if (to) $display("FAIL abort_recover_timeout got=no_done want=done");
    else if (lat !== e.lat) $display("FAIL abort_recover_latency got=%0d want=%0d", lat, e.lat);
    else passes++;
    checks++; if (s !== e.s) $display("FAIL abort_recover_s got=%h want=%h", s, e.s); else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    bit          to;
    bit          bok;
    logic [31:0] first_s;
    logic        first_ovf;
    sb.push_back('{32'hC0800000, 1'b0, 4});
    sb.push_back('{32'h80000000, 1'b0, 4});
    pulse_start(32'hC0000000, 32'hC0000000, 1'b0);
    wait_done(lat, to, bok);
    first_s   = s;
    first_ovf = overflow;
    e = sb.pop_front();
    checks++;
    if (to) $display("FAIL b2b_first_timeout got=no_done want=done");
    else if (lat !== e.lat) $display("FAIL b2b_first_latency got=%0d want=%0d", lat, e.lat);
    else passes++;
    checks++; if (first_s !== e.s) $display("FAIL b2b_first_s got=%h want=%h", first_s, e.s); else passes++;
    checks++; if (first_ovf !== e.ovf) $display("FAIL b2b_first_ovf got=%b want=%b", first_ovf, e.ovf); else passes++;
    pulse_start(32'h00800000, 32'h00800001, 1'b1);
    checks++; if (busy !== 1'b1) $display("FAIL b2b_accept_in_done_cycle got=%b want=1", busy); else passes++;
    wait_done(lat, to, bok);
    e = sb.pop_front();
    checks++;
    if (to) $display("FAIL b2b_second_timeout got=no_done want=done");
    else if (lat !== e.lat) $display("FAIL b2b_second_latency got=%0d want=%0d", lat, e.lat);
    else passes++;
    checks++; if (s !== e.s) $display("FAIL b2b_second_s got=%h want=%h", s, e.s); else passes++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
